// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive controllers.
package uart_pkg;

   localparam int FRAME_W  = 11;
   localparam int DATA_W   = 8;
   localparam int STOP_IDX = 10;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } state_e;

   // Frame is sent LSB first: start(0), data[0..7], parity, stop(1).
   function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] data,
                                                      input logic              parity_odd);
      return {1'b1, (^data) ^ parity_odd, data, 1'b0};
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and emits a tick on the last count.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: loads an 11-bit frame into the external shift register and paces its shifts.
module uart_tx_controller
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_ODD   = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               tx_busy,
   output logic               tx_done,
   output logic [FRAME_W-1:0] sr_data_p,
   output logic               sr_data_s,
   output logic               sr_load,
   output logic               sr_shift,
   input  logic               sr_bit,
   output logic               tx_out
);

   localparam logic [3:0] LAST_BIT = 4'(STOP_IDX);

   state_e             state_q, state_d;
   logic [3:0]         bit_idx_q, bit_idx_d;
   logic [FRAME_W-1:0] sr_data_p_q, sr_data_p_d;
   logic               baud_tick;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock (clock),
      .reset (reset),
      .clear (state_q == LOAD),
      .enable(state_q == SEND),
      .tick  (baud_tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_idx_q   <= '0;
         sr_data_p_q <= '0;
      end else begin
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         sr_data_p_q <= sr_data_p_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      sr_data_p_d = sr_data_p_q;
      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               sr_data_p_d = build_frame(tx_data, PARITY_ODD != 0);
               state_d     = LOAD;
            end
         end
         LOAD: begin
            bit_idx_d = '0;
            state_d   = SEND;
         end
         SEND: begin
            if (baud_tick) begin
               if (bit_idx_q == LAST_BIT)
                  state_d = IDLE;
               else
                  bit_idx_d = bit_idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs depend only on registered state/counters; sr_bit just passes through in SEND.
   always_comb begin
      tx_ready  = (state_q == IDLE);
      tx_busy   = (state_q != IDLE);
      sr_load   = (state_q == LOAD);
      sr_shift  = (state_q == SEND) && baud_tick && (bit_idx_q != LAST_BIT);
      tx_done   = (state_q == SEND) && baud_tick && (bit_idx_q == LAST_BIT);
      tx_out    = (state_q == SEND) ? sr_bit : 1'b1;
      sr_data_p = sr_data_p_q;
      sr_data_s = 1'b1;
   end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench: three controller configurations, each driving a behavioural 11-bit shift register.
module tb_uart_tx_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic [1:0] sel;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         start_cyc, done_cyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0]  vld, rdy, bsy, dn, dps, ld, sh, sb, to;
   logic [10:0] dp [3];
   logic [10:0] sr [3];

   assign vld[0] = tx_valid && (sel == 2'd0);
   assign vld[1] = tx_valid && (sel == 2'd1);
   assign vld[2] = tx_valid && (sel == 2'd2);
   assign sb[0] = sr[0][0];
   assign sb[1] = sr[1][0];
   assign sb[2] = sr[2][0];

   uart_tx_controller #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_e4 (
      .clock(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vld[0]), .tx_ready(rdy[0]),
      .tx_busy(bsy[0]), .tx_done(dn[0]), .sr_data_p(dp[0]), .sr_data_s(dps[0]), .sr_load(ld[0]),
      .sr_shift(sh[0]), .sr_bit(sb[0]), .tx_out(to[0]));
   uart_tx_controller #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_o4 (
      .clock(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vld[1]), .tx_ready(rdy[1]),
      .tx_busy(bsy[1]), .tx_done(dn[1]), .sr_data_p(dp[1]), .sr_data_s(dps[1]), .sr_load(ld[1]),
      .sr_shift(sh[1]), .sr_bit(sb[1]), .tx_out(to[1]));
   uart_tx_controller #(.CLKS_PER_BIT(2), .PARITY_ODD(0)) u_e2 (
      .clock(clk), .reset(reset), .tx_data(tx_data), .tx_valid(vld[2]), .tx_ready(rdy[2]),
      .tx_busy(bsy[2]), .tx_done(dn[2]), .sr_data_p(dp[2]), .sr_data_s(dps[2]), .sr_load(ld[2]),
      .sr_shift(sh[2]), .sr_bit(sb[2]), .tx_out(to[2]));

   // Behavioural shift register, reset directly as in the real system.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (reset)      sr[k] <= '0;
         else if (ld[k]) sr[k] <= dp[k];
         else if (sh[k]) sr[k] <= {dps[k], sr[k][10:1]};
      end
   end

   logic        o_rdy, o_bsy, o_dn, o_ld, o_sh, o_to;
   logic [10:0] o_dp;
   always_comb begin
      o_rdy = rdy[sel]; o_bsy = bsy[sel]; o_dn = dn[sel];
      o_ld  = ld[sel];  o_sh  = sh[sel];  o_to = to[sel];
      o_dp  = dp[sel];
   end

   typedef struct {
      logic [1:0]  sel;
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string nm, input logic [7:0] d, input logic [10:0] fr,
                       input bit hold, input logic [7:0] nd, input int pulse_at, input int abort_at);
      int clks, n, w, shifts, dones, done_at, bad_bits, xload, xrdy, ovl;
      clks = (sel == 2'd2) ? 2 : 4;
      n = 11 * clks;
      shifts = 0; dones = 0; done_at = -1; bad_bits = 0; xload = 0; xrdy = 0; ovl = 0;
      w = 0;
      while (!o_rdy && w < 50) begin step(); w++; end
      chk({nm, " ready"}, {31'd0, o_rdy}, 1);
      chk({nm, " idle line"}, {31'd0, o_to}, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      step();
      if (hold) tx_data = nd;
      else begin tx_valid = 1'b0; tx_data = ~d; end
      chk({nm, " load"}, {30'd0, o_ld, o_sh}, 32'd2);
      chk({nm, " frame"}, {21'd0, o_dp}, {21'd0, fr});
      chk({nm, " load ready/busy/line"}, {29'd0, o_rdy, o_bsy, o_to}, 32'd3);
      for (int c = 0; c < n; c++) begin
         step();
         if (c == 0) start_cyc = cyc;
         if (c == pulse_at) begin tx_valid = 1'b1; tx_data = 8'hFF; end
         if (c == pulse_at + 2) tx_valid = 1'b0;
         if (c == abort_at) begin
            reset = 1'b1;
            step();
            chk({nm, " abort ready/busy/done/line"}, {28'd0, o_rdy, o_bsy, o_dn, o_to}, 32'b1001);
            reset = 1'b0;
            return;
         end
         if (o_to !== fr[c / clks]) bad_bits++;
         if (o_ld) xload++;
         if (o_rdy) xrdy++;
         if (o_ld && o_sh) ovl++;
         if (o_sh) shifts++;
         if (o_dn) begin dones++; if (done_at < 0) done_at = c; end
      end
      done_cyc = cyc;
      chk({nm, " bad line cycles"}, bad_bits, 0);
      chk({nm, " shifts"}, shifts, 10);
      chk({nm, " done count"}, dones, 1);
      chk({nm, " done cycle"}, done_at, n - 1);
      chk({nm, " extra loads/overlap"}, xload + ovl, 0);
      chk({nm, " ready while busy"}, xrdy, 0);
      step();
      chk({nm, " post ready/busy/done/line"}, {28'd0, o_rdy, o_bsy, o_dn, o_to}, 32'b1001);
   endtask

   vec_t vecs [8];
   int   d1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{2'd0, 8'h55, 11'h4AA};
      vecs[1] = '{2'd0, 8'h07, 11'h60E};
      vecs[2] = '{2'd0, 8'h81, 11'h502};
      vecs[3] = '{2'd0, 8'hFF, 11'h5FE};
      vecs[4] = '{2'd1, 8'h55, 11'h6AA};
      vecs[5] = '{2'd1, 8'h00, 11'h600};
      vecs[6] = '{2'd2, 8'hFF, 11'h5FE};
      vecs[7] = '{2'd2, 8'h55, 11'h4AA};

      reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; sel = 2'd0;
      step(); step(); step();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset ctl %0d", k), {26'd0, rdy[k], bsy[k], dn[k], ld[k], sh[k], to[k]},
             32'b100001);
         chk($sformatf("reset frame %0d", k), {21'd0, dp[k]}, 0);
         chk($sformatf("fill bit %0d", k), {31'd0, dps[k]}, 1);
      end
      reset = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         sel = vecs[i].sel;
         send($sformatf("vec%0d", i), vecs[i].data, vecs[i].frame, 1'b0, 8'h00, -10, -10);
      end

      sel = 2'd0;
      send("b2b first", 8'hA0, 11'h540, 1'b1, 8'h3C, -10, -10);
      d1 = done_cyc;
      send("b2b second", 8'h3C, 11'h478, 1'b0, 8'h00, -10, -10);
      chk("b2b start gap", start_cyc - d1, 3);

      send("busy pulse", 8'h12, 11'h424, 1'b0, 8'h00, 10, -10);

      send("abort", 8'h55, 11'h4AA, 1'b0, 8'h00, -10, 17);
      send("after abort", 8'h00, 11'h400, 1'b0, 8'h00, -10, -10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
